// File: rtl/pipelined_bypass_adder.sv
// Pipelined carry-bypass adder with valid/ready handshake; stage k adds operand slice k.
// Optional SATURATE_EN (`ifdef) clamps S on signed overflow inside the final stage.

module pipelined_bypass_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             overFlow
);
  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / BLOCK;

  logic [STAGES-1:0] valid_w;
  logic [STAGES:0]   ready_w;

  // A stage can load when it is empty or its content moves on this cycle.
  always_comb begin
    ready_w = '0;
    ready_w[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      ready_w[k] = !valid_w[k] || ready_w[k+1];
  end

  assign in_ready  = ready_w[0];
  assign out_valid = valid_w[STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : stage_g
      localparam int INW = WIDTH - gi * SLICE;
      localparam int SW  = (gi + 1) * SLICE;

      logic [INW-1:0]   a_up, b_up;
      logic [SLICE-1:0] s_sl;
      logic             cin_sl, cout_sl, up_valid;
      logic [SW-1:0]    sum_next, sum_d, sum_reg;
      logic             valid_reg, carry_reg;

      if (gi == 0) begin : src_g
        assign a_up     = A;
        assign b_up     = B;
        assign cin_sl   = Cin;
        assign up_valid = in_valid;
        assign sum_next = s_sl;
      end else begin : src_g
        assign a_up     = stage_g[gi-1].opnd_g.a_reg;
        assign b_up     = stage_g[gi-1].opnd_g.b_reg;
        assign cin_sl   = stage_g[gi-1].carry_reg;
        assign up_valid = stage_g[gi-1].valid_reg;
        assign sum_next = {s_sl, stage_g[gi-1].sum_reg};
      end

      // Ripple inside each group; an all-propagate group forwards its carry-in unchanged.
      always_comb begin : slice_add
        logic gc, rc, p, x;
        gc   = cin_sl;
        rc   = 1'b0;
        p    = 1'b0;
        x    = 1'b0;
        s_sl = '0;
        for (int g = 0; g < NGRP; g++) begin
          rc = gc;
          p  = 1'b1;
          for (int j = 0; j < BLOCK; j++) begin
            x  = a_up[g*BLOCK+j] ^ b_up[g*BLOCK+j];
            p  = p & x;
            s_sl[g*BLOCK+j] = x ^ rc;
            rc = (a_up[g*BLOCK+j] & b_up[g*BLOCK+j]) | (x & rc);
          end
          gc = p ? gc : rc;
        end
        cout_sl = gc;
      end

      if (gi < STAGES - 1) begin : opnd_g
        logic [INW-SLICE-1:0] a_reg, b_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
          end else if (ready_w[gi] && up_valid) begin
            a_reg <= a_up[INW-1:SLICE];
            b_reg <= b_up[INW-1:SLICE];
          end
        end
      end

      if (gi == STAGES - 1) begin : fin_g
        logic ovf_next, ovf_reg;
        // Carry into the MSB recovered from the MSB sum bit.
        assign ovf_next = (a_up[SLICE-1] ^ b_up[SLICE-1] ^ s_sl[SLICE-1]) ^ cout_sl;
`ifdef SATURATE_EN
        assign sum_d = !ovf_next     ? sum_next :
                       a_up[INW-1]   ? {1'b1, {(WIDTH-1){1'b0}}} :
                                       {1'b0, {(WIDTH-1){1'b1}}};
`else
        assign sum_d = sum_next;
`endif
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            ovf_reg <= 1'b0;
          else if (ready_w[gi] && up_valid)
            ovf_reg <= ovf_next;
        end
        assign S        = sum_reg;
        assign Cout     = carry_reg;
        assign overFlow = ovf_reg;
      end else begin : mid_g
        assign sum_d = sum_next;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          sum_reg   <= '0;
        end else if (ready_w[gi]) begin
          valid_reg <= up_valid;
          if (up_valid) begin
            carry_reg <= cout_sl;
            sum_reg   <= sum_d;
          end
        end
      end

      assign valid_w[gi] = valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// Directed and randomised checks of pipelined_bypass_adder: a 32-bit/2-stage instance
// and a 16-bit/BLOCK=2/4-stage instance sharing clock and reset.
module tb_pipelined_bypass_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
  logic [31:0] a, b, s;
  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_cin, n_cout, n_ovf;
  logic [15:0] n_a, n_b, n_s;

  int errors = 0;
  int checks = 0;

  pipelined_bypass_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .S(s), .Cout(cout), .overFlow(ovf)
  );

  pipelined_bypass_adder #(.WIDTH(16), .BLOCK(2), .STAGES(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .A(n_a), .B(n_b), .Cin(n_cin), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .S(n_s), .Cout(n_cout), .overFlow(n_ovf)
  );

  // Reference model: {Cout, overFlow, S}.
  function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] r;
    logic        v;
    logic [31:0] o;
    r = {1'b0, x} + {1'b0, y} + {32'b0, c};
    v = (x[31] == y[31]) && (r[31] != x[31]);
    o = r[31:0];
`ifdef SATURATE_EN
    if (v) o = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {r[32], v, o};
  endfunction

  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] r;
    logic        v;
    logic [15:0] o;
    r = {1'b0, x} + {1'b0, y} + {16'b0, c};
    v = (x[15] == y[15]) && (r[15] != x[15]);
    o = r[15:0];
`ifdef SATURATE_EN
    if (v) o = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {r[16], v, o};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    n_in_valid = 1'b0; n_out_ready = 1'b1; n_a = '0; n_b = '0; n_cin = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL reset_s got=%h want=00000000", s); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (n_out_valid !== 1'b0) begin errors++; $display("FAIL reset_n_out_valid got=%b want=0", n_out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation through an idle pipeline; checks latency, result and single emission.
  task automatic test_single(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                             input logic tc, input logic [31:0] es_wrap, input logic [31:0] es_sat,
                             input logic ec, input logic ev);
    logic [31:0] es;
`ifdef SATURATE_EN
    es = es_sat;
`else
    es = es_wrap;
`endif
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got=%b want=1", name, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_early got out_valid=%b want=0", name, out_valid); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_latency got out_valid=%b want=1", name, out_valid); end
    checks++; if (s !== es) begin errors++; $display("FAIL %s_s got=%h want=%h", name, s, es); end
    checks++; if (cout !== ec) begin errors++; $display("FAIL %s_cout got=%b want=%b", name, cout, ec); end
    checks++; if (ovf !== ev) begin errors++; $display("FAIL %s_ovf got=%b want=%b", name, ovf, ev); end
    $display("op %s: A=%h B=%h Cin=%b -> S=%h Cout=%b overFlow=%b", name, ta, tb_v, tc, s, cout, ovf);
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_dup got out_valid=%b want=0", name, out_valid); end
  endtask

  task automatic test_directed();
    test_single("ovf_pos",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    test_single("ovf_neg",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    test_single("five_m5",   32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    test_single("bypass",    32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    test_single("ten_m5",    32'h0000_000A, 32'hFFFF_FFFB, 1'b0, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0);
    test_single("mixed",     32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 32'h2345_678A, 1'b0, 1'b0);
    test_single("slice_cy",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    test_single("upper_cy",  32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    test_single("min_min",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1);
    test_single("all_prop",  32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
  endtask

  // Eight offered back-to-back; out_ready low on loop cycles 3..6.
  task automatic test_back_to_back();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [33:0] exp_q [$];
    logic [33:0] e;
    logic [31:0] hold_s;
    logic        stalled, acc, drn;
    int sent, got, occ, full_seen;
    for (int i = 0; i < 8; i++) begin
      va[i] = 32'h1111_1111 * (i + 1);
      vb[i] = 32'h0001_0001 * i + 32'h0000_0100;
    end
    sent = 0; got = 0; occ = 0; full_seen = 0; stalled = 1'b0; hold_s = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      in_valid = (sent < 8);
      if (sent < 8) begin a = va[sent]; b = vb[sent]; cin = sent[0]; end
      out_ready = !(c >= 3 && c <= 6);
      #1;
      checks++;
      if (in_ready !== ((occ < 2) || out_ready)) begin
        errors++; $display("FAIL b2b_in_ready cycle=%0d got=%b occupancy=%0d out_ready=%b", c, in_ready, occ, out_ready);
      end
      if (!in_ready) full_seen++;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || s !== hold_s) begin
          errors++; $display("FAIL b2b_stall cycle=%0d got valid=%b S=%h want valid=1 S=%h", c, out_valid, s, hold_s);
        end
      end
      drn = out_valid && out_ready;
      acc = in_valid && in_ready;
      if (drn) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h0;
        checks++;
        if ({cout, ovf, s} !== e) begin
          errors++; $display("FAIL b2b_result idx=%0d got=%b/%b/%h want=%b/%b/%h", got, cout, ovf, s, e[33], e[32], e[31:0]);
        end
        $display("b2b out idx=%0d S=%h Cout=%b overFlow=%b", got, s, cout, ovf);
        got++;
      end
      if (acc) begin
        exp_q.push_back(model32(a, b, cin));
        $display("b2b in idx=%0d A=%h B=%h Cin=%b", sent, a, b, cin);
        sent++;
      end
      stalled = out_valid && !out_ready;
      hold_s  = s;
      occ = occ + (acc ? 1 : 0) - (drn ? 1 : 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", got); end
    checks++; if (full_seen == 0) begin errors++; $display("FAIL b2b_backpressure got in_ready_low_cycles=0 want>0"); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; a = 32'h1234_5678; b = 32'h0000_0001; cin = 1'b0;
    @(negedge clk);
    a = 32'h0000_FFFF; b = 32'h0000_0002;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b want=1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_pre_full got in_ready=%b want=0", in_ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
    checks++; if (s !== 32'h0) begin errors++; $display("FAIL mid_rst_s got=%h want=00000000", s); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got=%b want=1", in_ready); end
    $display("reset mid-flight: out_valid=%b S=%h", out_valid, s);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_stale got valid_cycles=%0d want=0", seen); end
  endtask

  task automatic test_sweep_latency();
    int lat;
    @(negedge clk);
    n_in_valid = 1'b1; n_a = 16'h7FFF; n_b = 16'h0001; n_cin = 1'b0; n_out_ready = 1'b1;
    @(negedge clk);
    n_in_valid = 1'b0;
    lat = 1;
    #1;
    while (n_out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL sweep_latency got=%0d want=4", lat); end
`ifdef SATURATE_EN
    checks++; if (n_s !== 16'h7FFF) begin errors++; $display("FAIL sweep_lat_s got=%h want=7fff", n_s); end
`else
    checks++; if (n_s !== 16'h8000) begin errors++; $display("FAIL sweep_lat_s got=%h want=8000", n_s); end
`endif
    checks++; if (n_ovf !== 1'b1) begin errors++; $display("FAIL sweep_lat_ovf got=%b want=1", n_ovf); end
    $display("sweep op: A=7fff B=0001 -> S=%h overFlow=%b latency=%0d", n_s, n_ovf, lat);
    @(negedge clk);
  endtask

  task automatic test_sweep_random();
    logic [17:0] exp_q [$];
    logic [17:0] e;
    logic        acc, drn;
    int sent, got;
    sent = 0; got = 0;
    n_in_valid = 1'b0;
    for (int c = 0; c < 6000 && got < 1000; c++) begin
      @(negedge clk);
      if (!n_in_valid && sent < 1000 && $urandom_range(0, 7) != 0) begin
        n_in_valid = 1'b1;
        n_a = 16'($urandom); n_b = 16'($urandom); n_cin = 1'($urandom);
      end
      n_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      drn = n_out_valid && n_out_ready;
      acc = n_in_valid && n_in_ready;
      if (drn) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h0;
        checks++;
        if ({n_cout, n_ovf, n_s} !== e) begin
          errors++; $display("FAIL sweep_result idx=%0d got=%b/%b/%h want=%b/%b/%h", got, n_cout, n_ovf, n_s, e[17], e[16], e[15:0]);
        end
        $display("sweep out idx=%0d S=%h Cout=%b overFlow=%b", got, n_s, n_cout, n_ovf);
        got++;
      end
      if (acc) begin
        exp_q.push_back(model16(n_a, n_b, n_cin));
        sent++;
      end
      // Deassert after the edge that accepts the pending operand.
      if (acc) begin
        @(posedge clk);
        #1 n_in_valid = 1'b0;
      end
    end
    n_in_valid = 1'b0; n_out_ready = 1'b1;
    checks++; if (got !== 1000) begin errors++; $display("FAIL sweep_count got=%0d want=1000", got); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_sweep_latency();
    test_sweep_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
